free_list: RTL

// Physical-register free list feeding rename/dispatch and fed by the reorder_buffer.

---
 rtl/free_list.sv | 87 ++++++++
 1 files changed

// File: rtl/free_list.sv
// Circular free list of physical register tags: pops one tag per dispatch, reclaims on retire and on rollback.
// Zero-cycle pop latency from registered head; pushes become visible the following cycle; blocked pushes latch overflow_err.
module free_list #(
    parameter int PR_W     = 6,
    parameter int NUM_PR   = 64,
    parameter int NUM_ARCH = 32,
    parameter int DEPTH    = NUM_PR - NUM_ARCH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    output logic [PR_W-1:0] alloc_pr,
    output logic            empty,
    input  logic            retire_reg,
    input  logic [PR_W-1:0] PR_old_RT,
    input  logic            recover,
    input  logic            RegDest_out,
    input  logic [PR_W-1:0] PR_new_flush,
    output logic [PR_W-1:0] free_count,
    output logic            overflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic [PR_W-1:0] entry [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   tail_fl;
    logic [PR_W-1:0] count;
    logic [PR_W-1:0] count_next;
    logic [PR_W:0]   room;
    logic            pop;
    logic            flush_req;
    logic            rt_ok;
    logic            fl_ok;
    logic            blocked;

    always_comb begin
        pop       = alloc_req && !recover && (count != '0);
        flush_req = recover && RegDest_out;
        // Slots available after this cycle's pop; retire claims one first.
        room      = (PR_W+1)'(DEPTH) - {1'b0, count} + {{PR_W{1'b0}}, pop};
        rt_ok     = retire_reg && (room != '0);
        fl_ok     = flush_req && (room > {{PR_W{1'b0}}, rt_ok});
        blocked   = (retire_reg && !rt_ok) || (flush_req && !fl_ok);
        tail_fl   = tail + AW'(rt_ok);
        count_next = count + PR_W'(rt_ok) + PR_W'(fl_ok) - PR_W'(pop);
    end

    assign alloc_pr   = entry[head];
    assign empty      = (count == '0);
    assign free_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= PR_W'(NUM_ARCH + i);
            end
        end else begin
            if (rt_ok) begin
                entry[tail] <= PR_old_RT;
            end
            if (fl_ok) begin
                entry[tail_fl] <= PR_new_flush;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= PR_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + AW'(1);
            end
            tail  <= tail + AW'(rt_ok) + AW'(fl_ok);
            count <= count_next;
            if (blocked) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
